// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end: the fetch state
// encoding, default reset address and PC increment, and the NOP word that
// fills the output buffer after reset.
package fetch_unit_pkg;

   typedef enum logic [1:0] {
      START = 2'd0,  // one idle cycle after reset, no request
      REQ   = 2'd1,  // request outstanding at fetch_pc
      DRAIN = 2'd2,  // buffer full, waiting for decode to accept
      DROP  = 2'd3   // waiting out an abandoned request after a redirect
   } fetch_state_e;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam int          DEFAULT_PC_STEP  = 4;
   localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

endpackage : fetch_unit_pkg

// File: rtl/fetch_unit.sv
// Instruction-fetch front end. Issues one request/acknowledge read per
// instruction at fetch_pc, parks the returned word in a one-entry
// valid/ready buffer for decode, and steers fetch_pc on redirects. A
// redirect that lands while a read is still outstanding keeps the old
// address on the bus until the memory acknowledges, then discards that data.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
   parameter int                PC_STEP  = DEFAULT_PC_STEP
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              inst_valid,
   output logic [DATA_W-1:0] inst_data,
   output logic [ADDR_W-1:0] inst_pc,
   input  logic              inst_ready,
   output logic [ADDR_W-1:0] pc_out,
   output logic [ADDR_W-1:0] next_pc
);

   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

   fetch_state_e      state;
   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] drop_addr;
   logic [ADDR_W-1:0] redirect_target;

   // Redirect targets are word aligned by clearing the two low address bits.
   assign redirect_target = {redirect_pc[ADDR_W-1:2], 2'b00};

   // Sequencing, output buffer and abandoned-address latch in one process.
   always_ff @(posedge clk) begin
      // NOTE: every register here is assigned with <= so all of them update
      // from the same pre-edge values; a blocking = would let later lines see
      // half-updated state and the order of statements would change behaviour.
      if (reset) begin
         state      <= START;
         fetch_pc   <= RESET_PC;
         drop_addr  <= RESET_PC;
         inst_valid <= 1'b0;
         inst_data  <= DATA_W'(NOP_WORD);
         inst_pc    <= '0;
      end else if (redirect) begin
         // The buffered instruction is squashed even if decode is ready now.
         fetch_pc   <= redirect_target;
         inst_valid <= 1'b0;
         case (state)
            REQ: begin
               if (imem_ack) begin
                  state <= REQ;
               end else begin
                  // Keep presenting the abandoned address until it completes.
                  state     <= DROP;
                  drop_addr <= fetch_pc;
               end
            end
            DROP: begin
               if (imem_ack) state <= REQ;
            end
            default: state <= REQ;
         endcase
      end else begin
         case (state)
            START: state <= REQ;
            REQ: begin
               if (imem_ack) begin
                  inst_data  <= imem_rdata;
                  inst_pc    <= fetch_pc;
                  inst_valid <= 1'b1;
                  fetch_pc   <= next_pc;
                  state      <= DRAIN;
               end
            end
            DRAIN: begin
               if (inst_ready) begin
                  inst_valid <= 1'b0;
                  state      <= REQ;
               end
            end
            DROP: begin
               if (imem_ack) state <= REQ;
            end
            default: state <= START;
         endcase
      end
   end

   // Memory interface is a pure decode of the state register, so it is
   // glitch-free and stable for the whole cycle.
   assign imem_req  = (state == REQ) || (state == DROP);
   assign imem_addr = (state == DROP) ? drop_addr : fetch_pc;
   assign pc_out    = fetch_pc;
   assign next_pc   = fetch_pc + STEP;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. A memory responder with programmable
// latency answers requests, and a stream model predicts which instruction
// address decode must receive next: sequential by 4, restarted at the
// aligned target on every redirect and at 0 on reset.
module tb_fetch_unit;

   logic        clk;
   logic        reset;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        inst_ready;
   logic [31:0] pc_out;
   logic [31:0] next_pc;

   fetch_unit dut (
      .clk        (clk),
      .reset      (reset),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .inst_valid (inst_valid),
      .inst_data  (inst_data),
      .inst_pc    (inst_pc),
      .inst_ready (inst_ready),
      .pc_out     (pc_out),
      .next_pc    (next_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Memory and model state
   int          lat;            // fixed wait cycles, or -1 for random 0..3
   bit          pending;
   int          wcnt;
   bit          stale_ack;      // force an ack with junk data this cycle
   logic [31:0] exp_pc;         // address decode must receive next
   int          xfers;
   bit          after_reset;
   bit          prev_hold_buf;
   logic [31:0] prev_data;
   logic [31:0] prev_ipc;
   bit          prev_req_hold;
   logic [31:0] prev_addr;
   bit          redir_chk;
   logic [31:0] redir_tgt;
   logic [31:0] watch_addr;
   int          watch_req;
   int          watch_xfer;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: check current outputs, answer memory, update the
   // model, then advance to 1ns after the next rising edge.
   task automatic cycle();
      if (after_reset) begin
         check("rst_req", imem_req, 1'b0);
         check("rst_pc", pc_out, 32'h0);
         check("rst_next_pc", next_pc, 32'h4);
         check("rst_valid", inst_valid, 1'b0);
         check("rst_data", inst_data, 32'h0);
         check("rst_ipc", inst_pc, 32'h0);
         after_reset = 1'b0;
      end
      if (prev_req_hold) begin
         check("req_hold", imem_req, 1'b1);
         check("addr_hold", imem_addr, prev_addr);
      end
      if (prev_hold_buf) begin
         check("buf_valid_hold", inst_valid, 1'b1);
         check("buf_data_hold", inst_data, prev_data);
         check("buf_pc_hold", inst_pc, prev_ipc);
      end
      if (redir_chk) begin
         check("redirect_pc_out", pc_out, redir_tgt);
         redir_chk = 1'b0;
      end
      check("next_pc", next_pc, pc_out + 32'd4);

      imem_ack   = 1'b0;
      imem_rdata = 32'h1234_5678;
      if (imem_req && !reset) begin
         if (!pending) begin
            pending = 1'b1;
            wcnt    = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
         end
         if (wcnt == 0) begin
            imem_ack   = 1'b1;
            imem_rdata = mem_word(imem_addr);
         end
      end
      if (stale_ack) begin
         imem_ack   = 1'b1;
         imem_rdata = 32'hDEAD_BEEF;
      end
      #1;

      if (reset) begin
         exp_pc        = 32'h0;
         pending       = 1'b0;
         after_reset   = 1'b1;
         prev_hold_buf = 1'b0;
         prev_req_hold = 1'b0;
         redir_chk     = 1'b0;
      end else begin
         if (redirect) begin
            exp_pc    = redirect_pc & 32'hFFFF_FFFC;
            redir_chk = 1'b1;
            redir_tgt = exp_pc;
         end else if (inst_valid && inst_ready) begin
            check("xfer_pc", inst_pc, exp_pc);
            check("xfer_data", inst_data, mem_word(exp_pc));
            if (inst_pc == watch_addr) watch_xfer++;
            exp_pc = exp_pc + 32'd4;
            xfers++;
         end
         prev_hold_buf = inst_valid && !inst_ready && !redirect;
         prev_data     = inst_data;
         prev_ipc      = inst_pc;
         prev_req_hold = imem_req && !imem_ack;
         prev_addr     = imem_addr;
         if (imem_req && imem_addr == watch_addr) watch_req++;
         if (imem_req && imem_ack) pending = 1'b0;
         else if (pending) wcnt--;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      reset    = 1'b1;
      redirect = 1'b0;
      for (int i = 0; i < n; i++) cycle();
      reset = 1'b0;
   endtask

   initial begin
      int          n;
      int          xb;
      logic [31:0] exp_pc_at;
      bit          exp_v [7] = '{0, 0, 1, 0, 1, 0, 1};

      reset       = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      inst_ready  = 1'b1;
      imem_ack    = 1'b0;
      imem_rdata  = 32'h0;
      lat         = 0;
      pending     = 1'b0;
      wcnt        = 0;
      stale_ack   = 1'b0;
      exp_pc      = 32'h0;
      xfers       = 0;
      after_reset = 1'b0;
      prev_hold_buf = 1'b0;
      prev_req_hold = 1'b0;
      redir_chk   = 1'b0;
      watch_addr  = 32'hFFFF_FFFF;
      watch_req   = 0;
      watch_xfer  = 0;
      @(posedge clk);
      #1;

      // Zero-wait memory, decode always ready: one instruction per 2 cycles.
      do_reset(2);
      for (int i = 0; i < 7; i++) begin
         check("seq_valid", inst_valid, exp_v[i]);
         if (exp_v[i]) begin
            exp_pc_at = 32'(((i / 2) - 1) * 4);
            check("seq_ipc", inst_pc, exp_pc_at);
         end
         if (i == 0) check("first_cycle_req", imem_req, 1'b0);
         cycle();
      end

      // Three wait cycles on the read of 0x4.
      do_reset(1);
      lat        = 0;
      watch_addr = 32'h4;
      watch_req  = 0;
      watch_xfer = 0;
      cycle();
      cycle();
      lat = 3;
      for (int i = 0; i < 8; i++) cycle();
      check("wait_req_cycles", 32'(watch_req), 32'd4);
      check("wait_xfer_once", 32'(watch_xfer), 32'd1);

      // Decode stalls for 5 cycles with a full buffer.
      lat        = 0;
      inst_ready = 1'b0;
      n = 0;
      while (!inst_valid && n < 20) begin
         cycle();
         n++;
      end
      check("stall_fill", inst_valid, 1'b1);
      for (int i = 0; i < 5; i++) begin
         check("stall_no_req", imem_req, 1'b0);
         cycle();
      end
      inst_ready = 1'b1;
      check("stall_still_valid", inst_valid, 1'b1);
      cycle();
      check("resume_req", imem_req, 1'b1);

      // Reset during an outstanding read; a stale ack in START is ignored.
      lat = 3;
      cycle();
      do_reset(1);
      stale_ack = 1'b1;
      cycle();
      stale_ack = 1'b0;
      lat = 0;
      for (int i = 0; i < 4; i++) cycle();

      // Redirect to 0x100 while the read of 0x8 waits two more cycles.
      do_reset(1);
      lat        = 0;
      inst_ready = 1'b1;
      watch_addr = 32'h8;
      watch_req  = 0;
      watch_xfer = 0;
      for (int i = 0; i < 5; i++) cycle();
      check("pre_redir_req", imem_req, 1'b1);
      check("pre_redir_addr", imem_addr, 32'h8);
      lat         = 2;
      redirect    = 1'b1;
      redirect_pc = 32'h100;
      cycle();
      redirect = 1'b0;
      check("drop_req", imem_req, 1'b1);
      check("drop_addr", imem_addr, 32'h8);
      cycle();
      cycle();
      lat = 0;
      check("post_drop_req", imem_req, 1'b1);
      check("post_drop_addr", imem_addr, 32'h100);
      cycle();
      check("redir_valid", inst_valid, 1'b1);
      check("redir_ipc", inst_pc, 32'h100);
      check("dropped_never_shown", 32'(watch_xfer), 32'd0);

      // Redirect to 0x203 while decode is accepting: the transfer is squashed.
      xb          = xfers;
      redirect    = 1'b1;
      redirect_pc = 32'h203;
      cycle();
      redirect = 1'b0;
      check("squash_no_xfer", 32'(xfers), 32'(xb));
      check("squash_valid", inst_valid, 1'b0);
      check("squash_addr", imem_addr, 32'h200);

      // Wrap-around from the top of the address space.
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFE;
      cycle();
      redirect = 1'b0;
      check("wrap_pc", pc_out, 32'hFFFF_FFFC);
      check("wrap_next_pc", next_pc, 32'h0);
      cycle();
      check("wrap_ipc", inst_pc, 32'hFFFF_FFFC);
      cycle();
      check("wrap_addr", imem_addr, 32'h0);
      check("wrap_req", imem_req, 1'b1);

      // Random traffic: latency, stalls, redirects and occasional resets.
      lat = -1;
      xb  = xfers;
      for (int i = 0; i < 3000; i++) begin
         inst_ready = ($urandom_range(0, 3) != 0);
         redirect   = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | ($urandom() & 32'hF);
         else redirect_pc = $urandom() & 32'h0000_FFFF;
         reset = ($urandom_range(0, 199) == 0);
         cycle();
      end
      reset    = 1'b0;
      redirect = 1'b0;
      check("random_progress", 32'(xfers - xb >= 200), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_fetch_unit
